// File: rtl/axi_lite_mem_pkg.sv
// Shared types and helpers for the AXI4-Lite slave memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: resp_t, RESP_OKAY/RESP_SLVERR response codes, clog2_safe().
package axi_lite_mem_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // ceil(log2(value)), never less than 1 so it can size pointers and indices.
  function automatic int clog2_safe(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between a master and the slave memory.
// Latency: n/a (wires only).
// Backpressure: plain AXI valid/ready on all five channels.
// Ports: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//        B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//        R (rdata/rresp/rvalid/rready).
interface axi_lite_mem_slave_if
  import axi_lite_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  resp_t               bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  resp_t               rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_resp_fifo.sv
// Small in-order response FIFO (power-of-2 depth) for the B and R channels.
// Latency: push at edge N is visible on pop_dat / !empty after edge N.
// Backpressure: full/empty are registered; push while full is accepted only with a same-cycle pop.
// Ports: clk, rst (async active-high), push/push_dat, pop/pop_dat, empty, full.
module axi_lite_resp_fifo
  import axi_lite_mem_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = clog2_safe(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign pop_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave memory: byte-strobed writes, fixed-latency reads, SLVERR beyond DEPTH.
// Latency: AW+W handshake at T -> bvalid at T+2; AR handshake at T -> rvalid at T+RD_LAT.
// Backpressure: awready/wready drop while the holder is full or the B FIFO is full;
//               arready drops once OUTST reads are in the pipeline or waiting in the R FIFO.
// Ports: aclk, areset (async active-high, released synchronously upstream), bus (slave modport).
module axi_lite_mem_slave
  import axi_lite_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int OUTST  = 4
)(
  input  logic                 aclk,
  input  logic                 areset,
  axi_lite_mem_slave_if.slave  bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = clog2_safe(STRB_W);
  localparam int MEM_AW = clog2_safe(DEPTH);
  localparam int CNT_W  = clog2_safe(OUTST) + 1;
  localparam int R_W    = DATA_W + 2;
  localparam int NSTG   = (RD_LAT > 1) ? RD_LAT - 1 : 1;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return 32'(a >> LSB) < 32'(DEPTH);
  endfunction

  function automatic logic [MEM_AW-1:0] mem_index(input logic [ADDR_W-1:0] a);
    return MEM_AW'(a >> LSB);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // Readies stay low through reset and rise on the first edge after release.
  logic out_en;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) out_en <= 1'b0;
    else        out_en <= 1'b1;
  end

  // ---------------- write path ----------------
  logic              aw_full;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_full;
  logic [DATA_W-1:0] w_dat;
  logic [STRB_W-1:0] w_strb;
  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic              b_empty;
  logic              b_full;
  resp_t             b_resp_new;
  resp_t             b_head;

  assign bus.awready = out_en && !aw_full && !b_full;
  assign bus.wready  = out_en && !w_full && !b_full;
  assign aw_hs       = bus.awvalid && bus.awready;
  assign w_hs        = bus.wvalid && bus.wready;

  // Both holders are only refilled after commit clears them, so a capture and
  // a commit never land on the same holder in the same cycle. The B FIFO had
  // room at capture time and nothing else pushes it, so commit cannot overflow it.
  assign commit     = aw_full && w_full;
  assign b_resp_new = addr_ok(aw_addr) ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
      w_full  <= 1'b0;
      w_dat   <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= bus.awaddr;
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_dat  <= bus.wdata;
        w_strb <= bus.wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge aclk) begin
    if (commit && addr_ok(aw_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) mem[mem_index(aw_addr)][8*b +: 8] <= w_dat[8*b +: 8];
      end
    end
  end

  axi_lite_resp_fifo #(
    .WIDTH (2),
    .DEPTH (OUTST)
  ) u_b_fifo (
    .clk      (aclk),
    .rst      (areset),
    .push     (commit),
    .push_dat (b_resp_new),
    .pop      (bus.bready),
    .pop_dat  (b_head),
    .empty    (b_empty),
    .full     (b_full)
  );

  assign bus.bvalid = !b_empty;
  assign bus.bresp  = b_head;

  // ---------------- read path ----------------
  logic              ar_hs;
  logic              r_pop;
  logic [CNT_W-1:0]  rd_inflight;
  logic [DATA_W-1:0] rd_word;
  logic [R_W-1:0]    rd_entry;
  logic              r_push;
  logic [R_W-1:0]    r_push_dat;
  logic [R_W-1:0]    r_head;
  logic              r_empty;
  logic              r_full;

  // rd_inflight counts pipeline entries plus R FIFO entries, so holding it
  // below OUTST reserves a FIFO slot for every accepted read. r_full is
  // redundant with that credit and only guards against a mis-parameterisation.
  assign bus.arready = out_en && (rd_inflight < CNT_W'(OUTST)) && !r_full;
  assign ar_hs       = bus.arvalid && bus.arready;
  assign r_pop       = bus.rvalid && bus.rready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_inflight <= '0;
    end else begin
      case ({ar_hs, r_pop})
        2'b10:   rd_inflight <= rd_inflight + 1'b1;
        2'b01:   rd_inflight <= rd_inflight - 1'b1;
        default: rd_inflight <= rd_inflight;
      endcase
    end
  end

  // Sampled combinationally before the edge, so a write committing on the AR
  // edge is not seen (read-before-write).
  assign rd_word  = mem[mem_index(bus.araddr)];
  assign rd_entry = addr_ok(bus.araddr) ? {RESP_OKAY, rd_word}
                                        : {RESP_SLVERR, {DATA_W{1'b0}}};

  // The R FIFO write is the last of the RD_LAT stages, so only RD_LAT-1
  // registers sit in front of it. The pipeline never stalls: credit above
  // guarantees the FIFO has room when an entry arrives.
  if (RD_LAT == 1) begin : g_no_pipe
    assign r_push     = ar_hs;
    assign r_push_dat = rd_entry;
  end else begin : g_pipe
    logic [NSTG-1:0] stg_vld;
    logic [R_W-1:0]  stg_dat [NSTG];

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        stg_vld <= '0;
        for (int i = 0; i < NSTG; i++) stg_dat[i] <= '0;
      end else begin
        stg_vld[0] <= ar_hs;
        stg_dat[0] <= rd_entry;
        for (int i = 1; i < NSTG; i++) begin
          stg_vld[i] <= stg_vld[i-1];
          stg_dat[i] <= stg_dat[i-1];
        end
      end
    end

    assign r_push     = stg_vld[NSTG-1];
    assign r_push_dat = stg_dat[NSTG-1];
  end

  axi_lite_resp_fifo #(
    .WIDTH (R_W),
    .DEPTH (OUTST)
  ) u_r_fifo (
    .clk      (aclk),
    .rst      (areset),
    .push     (r_push),
    .push_dat (r_push_dat),
    .pop      (bus.rready),
    .pop_dat  (r_head),
    .empty    (r_empty),
    .full     (r_full)
  );

  assign bus.rvalid = !r_empty;
  assign bus.rresp  = r_head[R_W-1 -: 2];
  assign bus.rdata  = r_head[DATA_W-1:0];

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave: two instances (DEPTH 1024 and 512)
// share identical stimulus; expected B/R responses are queued when issued and
// compared by a negedge monitor when each response handshakes.
module tb_axi_lite_mem_slave;

  localparam int RD_LAT = 2;
  localparam int OUTST  = 4;

  logic aclk = 1'b0;
  logic areset;

  always #5 aclk = ~aclk;

  axi_lite_mem_slave_if #(.ADDR_W(12), .DATA_W(32)) bus  ();
  axi_lite_mem_slave_if #(.ADDR_W(12), .DATA_W(32)) bus2 ();

  axi_lite_mem_slave #(
    .ADDR_W(12), .DATA_W(32), .DEPTH(1024), .RD_LAT(RD_LAT), .OUTST(OUTST)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  axi_lite_mem_slave #(
    .ADDR_W(12), .DATA_W(32), .DEPTH(512), .RD_LAT(RD_LAT), .OUTST(OUTST)
  ) dut512 (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus2)
  );

  assign bus2.awaddr  = bus.awaddr;
  assign bus2.awvalid = bus.awvalid;
  assign bus2.wdata   = bus.wdata;
  assign bus2.wstrb   = bus.wstrb;
  assign bus2.wvalid  = bus.wvalid;
  assign bus2.bready  = bus.bready;
  assign bus2.araddr  = bus.araddr;
  assign bus2.arvalid = bus.arvalid;
  assign bus2.rready  = bus.rready;

  typedef struct packed {
    logic [1:0] r1;
    logic [1:0] r2;
  } b_exp_t;

  typedef struct packed {
    logic [31:0] d1;
    logic [1:0]  r1;
    logic [31:0] d2;
    logic [1:0]  r2;
  } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  b_exp_t mon_b;
  r_exp_t mon_r;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Response monitor: a handshake sampled here completes on the next rising edge.
  always @(negedge aclk) begin
    if (!areset) begin
      if (bus.bvalid && bus.bready) begin
        chk("b_expected", 64'(exp_b.size() != 0), 1);
        chk("b_vld_d512", bus2.bvalid, 1);
        if (exp_b.size() != 0) begin
          mon_b = exp_b.pop_front();
          chk("bresp_d1024", bus.bresp, mon_b.r1);
          chk("bresp_d512", bus2.bresp, mon_b.r2);
        end
      end
      if (bus.rvalid && bus.rready) begin
        chk("r_expected", 64'(exp_r.size() != 0), 1);
        chk("r_vld_d512", bus2.rvalid, 1);
        if (exp_r.size() != 0) begin
          mon_r = exp_r.pop_front();
          chk("rdata_d1024", bus.rdata, mon_r.d1);
          chk("rresp_d1024", bus.rresp, mon_r.r1);
          chk("rdata_d512", bus2.rdata, mon_r.d2);
          chk("rresp_d512", bus2.rresp, mon_r.r2);
        end
      end
    end
  end

  task automatic write_both(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] e1, input logic [1:0] e2, output int lat);
    bit aw_done;
    bit w_done;
    int c;
    exp_b.push_back({e1, e2});
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    aw_done = 0;
    w_done  = 0;
    c = 0;
    while (!(aw_done && w_done) && c < 50) begin
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      tick();
      c++;
      if (aw_done) bus.awvalid = 1'b0;
      if (w_done)  bus.wvalid  = 1'b0;
    end
    chk("wr_handshake", 64'(aw_done && w_done), 1);
    lat = 1;
    while (!bus.bvalid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic read(input logic [11:0] a, input logic [31:0] d1, input logic [1:0] r1,
                      input logic [31:0] d2, input logic [1:0] r2, output int lat);
    bit done;
    int c;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    done = 0;
    c = 0;
    while (!done && c < 50) begin
      if (bus.arready) begin
        done = 1;
        exp_r.push_back({d1, r1, d2, r2});
      end
      tick();
      c++;
    end
    bus.arvalid = 1'b0;
    chk("rd_handshake", done, 1);
    lat = 1;
    while (!bus.rvalid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && c < 200) begin
      tick();
      c++;
    end
    chk(tag, 64'(exp_b.size() + exp_r.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  c;
    int  issued;
    bit  done;

    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    areset      = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_rdata", bus.rdata, 0);
    areset = 1'b0;
    tick();
    chk("post_rst_awready", bus.awready, 1);
    chk("post_rst_wready", bus.wready, 1);
    chk("post_rst_arready", bus.arready, 1);

    // 1: single write then read, latency checks
    write_both(12'h010, 32'hDEADBEEF, 4'hF, 2'b00, 2'b00, lat);
    chk("t1_b_latency", lat, 2);
    drain("t1_b_drain");
    read(12'h010, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 2'b00, lat);
    chk("t1_r_latency", lat, RD_LAT);
    drain("t1_r_drain");

    // 2: W three cycles ahead of AW, partial strobe
    write_both(12'h020, 32'hFFFFFFFF, 4'hF, 2'b00, 2'b00, lat);
    drain("t2_pre_drain");
    exp_b.push_back({2'b00, 2'b00});
    bus.wdata  = 32'h00001234;
    bus.wstrb  = 4'h3;
    bus.wvalid = 1'b1;
    done = 0;
    c = 0;
    while (!done && c < 50) begin
      if (bus.wready) done = 1;
      tick();
      c++;
    end
    bus.wvalid = 1'b0;
    chk("t2_w_handshake", done, 1);
    chk("t2_wready_held", bus.wready, 0);
    chk("t2_awready_open", bus.awready, 1);
    repeat (2) tick();
    chk("t2_no_early_b", bus.bvalid, 0);
    bus.awaddr  = 12'h020;
    bus.awvalid = 1'b1;
    done = 0;
    c = 0;
    while (!done && c < 50) begin
      if (bus.awready) done = 1;
      tick();
      c++;
    end
    bus.awvalid = 1'b0;
    chk("t2_aw_handshake", done, 1);
    drain("t2_b_drain");
    read(12'h020, 32'hFFFF1234, 2'b00, 32'hFFFF1234, 2'b00, lat);
    drain("t2_r_drain");

    // 3: top word of 1024-deep memory; out of range for the 512-deep one
    write_both(12'hFFC, 32'hA5A55A5A, 4'hF, 2'b00, 2'b10, lat);
    drain("t3_b_drain");
    read(12'hFFC, 32'hA5A55A5A, 2'b00, 32'h0, 2'b10, lat);
    drain("t3_r_drain");

    // 4: outstanding-read limit with rready held low
    for (int i = 0; i < 6; i++) begin
      write_both(12'h100 + 12'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 2'b00, 2'b00, lat);
    end
    drain("t4_pre_drain");
    bus.rready  = 1'b0;
    issued      = 0;
    bus.araddr  = 12'h100;
    bus.arvalid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.arready && issued < 6) begin
        exp_r.push_back({32'hC0DE0000 + 32'(issued), 2'b00, 32'hC0DE0000 + 32'(issued), 2'b00});
        issued++;
      end
      tick();
      if (issued < 6) bus.araddr = 12'h100 + 12'(4 * issued);
      else            bus.arvalid = 1'b0;
    end
    chk("t4_accepted", issued, OUTST);
    chk("t4_arready_stall", bus.arready, 0);
    chk("t4_rvalid_stall", bus.rvalid, 1);
    chk("t4_rdata_head", bus.rdata, 32'hC0DE0000);
    bus.rready = 1'b1;
    chk("t4_arready_until_pop", bus.arready, 0);
    tick();
    chk("t4_arready_after_pop", bus.arready, 1);
    c = 0;
    while (issued < 6 && c < 50) begin
      if (bus.arready) begin
        exp_r.push_back({32'hC0DE0000 + 32'(issued), 2'b00, 32'hC0DE0000 + 32'(issued), 2'b00});
        issued++;
      end
      tick();
      c++;
      if (issued < 6) bus.araddr = 12'h100 + 12'(4 * issued);
      else            bus.arvalid = 1'b0;
    end
    bus.arvalid = 1'b0;
    chk("t4_all_issued", issued, 6);
    drain("t4_drain");

    // 5: AR handshake on the same edge as a write commit sees old data
    write_both(12'h040, 32'h11111111, 4'hF, 2'b00, 2'b00, lat);
    drain("t5_pre_drain");
    chk("t5_awready", bus.awready, 1);
    chk("t5_wready", bus.wready, 1);
    exp_b.push_back({2'b00, 2'b00});
    bus.awaddr  = 12'h040;
    bus.wdata   = 32'h22222222;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.araddr  = 12'h040;
    bus.arvalid = 1'b1;
    chk("t5_arready_commit_edge", bus.arready, 1);
    exp_r.push_back({32'h11111111, 2'b00, 32'h11111111, 2'b00});
    tick();
    bus.arvalid = 1'b0;
    drain("t5_drain");
    read(12'h040, 32'h22222222, 2'b00, 32'h22222222, 2'b00, lat);
    drain("t5_new_drain");

    // 6: reset with two reads in flight drops them
    bus.rready  = 1'b0;
    bus.araddr  = 12'h010;
    bus.arvalid = 1'b1;
    tick();
    tick();
    bus.arvalid = 1'b0;
    chk("t6_rvalid_before_rst", bus.rvalid, 1);
    areset = 1'b1;
    #1;
    chk("t6_rvalid_in_rst", bus.rvalid, 0);
    chk("t6_arready_in_rst", bus.arready, 0);
    tick();
    areset = 1'b0;
    tick();
    chk("t6_arready_after_rst", bus.arready, 1);
    bus.rready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t6_no_rvalid", bus.rvalid, 0);
      tick();
    end
    chk("t6_no_bvalid", bus.bvalid, 0);
    read(12'h010, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 2'b00, lat);
    chk("t6_r_latency", lat, RD_LAT);
    drain("t6_drain");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
